l1a_event_buffer: RTL
=====================

# l1a_event_buffer

Downstream of the L1 event generator: captures each L1A together with the BCID and hits count presented on the same cycle and tags it with a running event number. It queues the tagged events in a synchronous FIFO and hands them to the readout formatter over a valid/ready handshake. It also counts events dropped while the queue is full.

## Interface
Parameters:
- ADDR_W, 4: FIFO address width; depth = 2^ADDR_W entries (16).
- OVF_W, 16: overflow counter width.

Ports:
- clk  in  1  40 MHz system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- L1A  in  1  trigger strobe from generator, one cycle per trigger.
- BCID  in  12  bunch-crossing ID, valid on the L1A cycle.
- hitsCount  in  9  hits count, valid on the L1A cycle.
- flush  in  1  synchronous FIFO clear; does not reset event number or overflow count.
- clearOverflow  in  1  synchronous clear of overflowCount.
- evtData  out  33  head entry: [32:21] eventNum, [20:9] BCID, [8:0] hitsCount.
- evtValid  out  1  head entry present.
- evtReady  in  1  consumer accepts head when evtValid & evtReady.
- level  out  ADDR_W+1  current occupancy, 0..2^ADDR_W.
- full  out  1  level == 2^ADDR_W.
- overflowCount  out  OVF_W  dropped-event count, saturating.

## Operation
- Capture: on each rising edge with L1A=1, form the entry {eventNum, BCID, hitsCount}.
- Write rule: write if not full, or if a read occurs on the same edge.
- Dropped event: if full and no read, discard the entry. overflowCount increments, saturating at 2^OVF_W-1.
- eventNum: 12-bit counter, reset 0. Increments on every L1A, accepted or dropped, so readout gaps expose drops. Wraps 4095→0.
- First event after reset carries eventNum=0.
- Read: on evtValid & evtReady, pop the head. evtReady while evtValid=0 is ignored.
- evtData: stable while evtValid=1 and evtReady=0. It is don't-care (held at last value) when evtValid=0.
- flush=1 on an edge: pointers and level go to 0, evtValid goes to 0 next cycle, and any L1A on that edge is dropped. The dropped L1A does not increment overflowCount; eventNum still advances.
- clearOverflow and an overflow on the same edge: the result is 1, not 0.
- Reset values: evtValid=0, evtData=0, level=0, full=0, overflowCount=0, eventNum=0, pointers=0.
- Reset asserted mid-operation discards all queued entries immediately and asynchronously.

## Timing
- Write-to-valid latency: 1 cycle. An entry captured at edge N makes evtValid=1 after edge N; there is no same-cycle bypass of L1A into evtValid.
- Pop at edge N: the next entry is on evtData after edge N, so back-to-back reads sustain 1 entry/cycle.
- level, full, overflowCount: registered, updated on the same edge as the write/read that changes them.
- Simultaneous read and write: level unchanged.
- Simultaneous read and write at full: the write is accepted and level stays 2^ADDR_W.
- Simultaneous read and write at empty: there is no head to read, so level becomes 1.
- Pointers: ADDR_W+1 bits wide, wrapping naturally. full/empty are derived from the MSB compare.

## Structure
- Package l1a_buffer_pkg holds:
  - ENTRY_W=33;
  - field offsets EVT_LSB=21, BCID_LSB=9, HITS_LSB=0;
  - BCID_W=12, HITS_W=9, EVTNUM_W=12;
  - a function to pack an entry.
- One sub-module, sync_fifo_fwft: a parameterised single-clock first-word-fall-through FIFO with write-accept-on-full-with-read, flush, and level output.
- The top level holds the event counter, packing, overflow counter and handshake glue.

## Test plan
- Single L1A with BCID=100, hitsCount=5 after reset, evtReady=1 → one cycle later evtValid=1 and evtData={0,100,5}; popped next edge; level returns 0.
- 20 L1A on consecutive cycles with evtReady=0 → level=16, full=1, overflowCount=4, eventNums 0..15 stored. Then draining 16 reads returns eventNum 0..15 in order.
- Full FIFO, L1A and evtReady=1 on the same edge → write accepted, level stays 16, overflowCount unchanged.
- 4096 L1As with continuous evtReady=1 → eventNum wraps 4095→0, no drops.
- Repeated overflow until overflowCount=65535 → it saturates. clearOverflow together with an overflow on one edge → overflowCount=1.
- Stimulus during operation:
  - flush with 5 entries queued and L1A on the same edge → level=0 and evtValid=0 next cycle, the next L1A carries eventNum+2;
  - asynchronous reset pulse mid-burst → all outputs immediately at reset values.

Source files
------------

// File: rtl/l1a_event_buffer_pkg.sv
// Shared widths, field offsets and the entry packing helper for the
// L1A event buffer.
package l1a_buffer_pkg;

    localparam int ENTRY_W  = 33;
    localparam int EVT_LSB  = 21;
    localparam int BCID_LSB = 9;
    localparam int HITS_LSB = 0;
    localparam int BCID_W   = 12;
    localparam int HITS_W   = 9;
    localparam int EVTNUM_W = 12;

    // Build one queue entry: {eventNum, BCID, hitsCount}.
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [EVTNUM_W-1:0] evt_num,
        input logic [BCID_W-1:0]   bcid,
        input logic [HITS_W-1:0]   hits
    );
        logic [ENTRY_W-1:0] entry;
        entry                        = {ENTRY_W{1'b0}};
        entry[EVT_LSB  +: EVTNUM_W]  = evt_num;
        entry[BCID_LSB +: BCID_W]    = bcid;
        entry[HITS_LSB +: HITS_W]    = hits;
        return entry;
    endfunction

endpackage

// File: rtl/l1a_event_buffer_if.sv
// Trigger input and readout handshake of the L1A event buffer.
// The buffer is the master of the readout stream; the formatter is the slave.
interface l1a_event_buffer_if;
    import l1a_buffer_pkg::*;

    logic                L1A;
    logic [BCID_W-1:0]   BCID;
    logic [HITS_W-1:0]   hitsCount;
    logic [ENTRY_W-1:0]  evtData;
    logic                evtValid;
    logic                evtReady;

    modport master (
        input  L1A,
        input  BCID,
        input  hitsCount,
        input  evtReady,
        output evtData,
        output evtValid
    );

    modport slave (
        output L1A,
        output BCID,
        output hitsCount,
        output evtReady,
        input  evtData,
        input  evtValid
    );

endinterface

// File: rtl/l1a_event_buffer_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head entry is held in a
// register so it is reset to zero and stays put while the FIFO is empty.
// A write is accepted at full when a read happens on the same edge.
module sync_fifo_fwft #(
    parameter int DATA_W = 33,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_drop,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   level,
    output logic              full
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH_LVL = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W:0]   wr_ptr_r;
    logic [ADDR_W:0]   rd_ptr_r;
    logic [ADDR_W:0]   level_r;
    logic              full_r;
    logic              valid_r;
    logic [DATA_W-1:0] data_r;

    logic              empty_s;
    logic              full_s;
    logic              rd_en_s;
    logic              wr_en_s;
    logic              drop_s;
    logic [ADDR_W:0]   wr_ptr_next_s;
    logic [ADDR_W:0]   rd_ptr_next_s;
    logic [ADDR_W:0]   level_next_s;
    logic [DATA_W-1:0] data_next_s;

    // Status from the pointers and the accept/drop decision for this edge.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
                  (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
        rd_en_s = rd_req && !empty_s && !flush;
        wr_en_s = wr_req && !flush && (!full_s || rd_en_s);
        drop_s  = wr_req && !flush && full_s && !rd_en_s;
    end

    // Next pointers, occupancy and head entry.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        level_next_s  = level_r;
        data_next_s   = data_r;
        if (flush) begin
            wr_ptr_next_s = PTR_ZERO;
            rd_ptr_next_s = PTR_ZERO;
            level_next_s  = PTR_ZERO;
        end else begin
            if (wr_en_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   level_next_s = level_r + PTR_ONE;
                2'b01:   level_next_s = level_r - PTR_ONE;
                default: level_next_s = level_r;
            endcase
        end
        // The new head is the entry written this edge only when it lands
        // in the slot the read pointer will point at; otherwise it is in RAM.
        if (level_next_s == PTR_ZERO) begin
            data_next_s = data_r;
        end else if (wr_en_s &&
                     (wr_ptr_r[ADDR_W-1:0] == rd_ptr_next_s[ADDR_W-1:0])) begin
            data_next_s = wr_data;
        end else begin
            data_next_s = mem_r[rd_ptr_next_s[ADDR_W-1:0]];
        end
    end

    // Pointer, occupancy and head registers; reset empties the queue at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= PTR_ZERO;
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
            data_r   <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            level_r  <= level_next_s;
            full_r   <= (level_next_s == DEPTH_LVL);
            valid_r  <= (level_next_s != PTR_ZERO);
            data_r   <= data_next_s;
        end
    end

    // Storage array; contents are meaningless once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign wr_drop  = drop_s;
    assign rd_data  = data_r;
    assign rd_valid = valid_r;
    assign level    = level_r;
    assign full     = full_r;

endmodule

// File: rtl/l1a_event_buffer.sv
// L1A event buffer: tags each trigger with a running event number, queues
// it for the readout formatter and counts triggers lost to a full queue.
module l1a_event_buffer
    import l1a_buffer_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int OVF_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    l1a_event_buffer_if.master  bus,
    input  logic                flush,
    input  logic                clearOverflow,
    output logic [ADDR_W:0]     level,
    output logic                full,
    output logic [OVF_W-1:0]    overflowCount
);

    localparam logic [EVTNUM_W-1:0] EVT_ZERO = {EVTNUM_W{1'b0}};
    localparam logic [EVTNUM_W-1:0] EVT_ONE  = {{(EVTNUM_W-1){1'b0}}, 1'b1};
    localparam logic [OVF_W-1:0]    OVF_ZERO = {OVF_W{1'b0}};
    localparam logic [OVF_W-1:0]    OVF_ONE  = {{(OVF_W-1){1'b0}}, 1'b1};
    localparam logic [OVF_W-1:0]    OVF_MAX  = {OVF_W{1'b1}};

    logic [EVTNUM_W-1:0] evt_num_r;
    logic [OVF_W-1:0]    ovf_r;
    logic [ENTRY_W-1:0]  entry_s;
    logic                drop_s;

    assign entry_s = pack_entry(evt_num_r, bus.BCID, bus.hitsCount);

    // Event number advances on every trigger, even dropped or flushed ones,
    // so gaps in the readout sequence reveal losses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_num_r <= EVT_ZERO;
        end else if (bus.L1A) begin
            evt_num_r <= evt_num_r + EVT_ONE;
        end else begin
            evt_num_r <= evt_num_r;
        end
    end

    // Saturating drop counter; a drop on the clearing edge still counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= OVF_ZERO;
        end else if (clearOverflow) begin
            ovf_r <= drop_s ? OVF_ONE : OVF_ZERO;
        end else if (drop_s && (ovf_r != OVF_MAX)) begin
            ovf_r <= ovf_r + OVF_ONE;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    sync_fifo_fwft #(
        .DATA_W (ENTRY_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .wr_req   (bus.L1A),
        .wr_data  (entry_s),
        .wr_drop  (drop_s),
        .rd_req   (bus.evtReady),
        .rd_data  (bus.evtData),
        .rd_valid (bus.evtValid),
        .level    (level),
        .full     (full)
    );

    assign overflowCount = ovf_r;

endmodule
